// File: rtl/pipelined_exec_unit.sv
// RV integer execute unit: ALU ops registered in 1 cycle, M-ops iterate 1 bit/cycle (XLEN+2 edges).
// Backpressure: a held result blocks in_ready until out_ready; kill or reset drops in-flight work.
module pipelined_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      func,
  input  logic [6:0]      aux_func,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2:0]        fn;
  logic              neg;
  logic              bzero;
  logic [XLEN-1:0]   a_save;
  logic [XLEN-1:0]   mag;
  logic [2*XLEN-1:0] acc;

  logic              accept;
  logic              is_m;
  logic              last;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   sra_res;
  logic [XLEN-1:0]   alu_res;
  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     msum, dshift, dtrial;
  logic [2*XLEN-1:0] mres;
  logic [XLEN-1:0]   dval;
  logic [XLEN-1:0]   fix_res;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !kill;
  assign is_m     = (aux_func == 7'b0000001);
  assign busy     = (state != IDLE);
  assign last     = (cnt == CW'(XLEN));
  assign shamt    = op_b[SHW-1:0];
  assign sra_res  = $signed(op_a) >>> shamt;

  always_comb begin
    alu_res = '0;
    case (func)
      3'b000:  alu_res = aux_func[5] ? op_a - op_b : op_a + op_b;
      3'b001:  alu_res = op_a << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = aux_func[5] ? sra_res : op_a >> shamt;
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  // Operand signedness: MUL/MULH/MULHSU treat a as signed, only MUL/MULH treat b as signed;
  // DIV/REM are signed on both, DIVU/REMU on neither.
  always_comb begin
    a_sgn = func[2] ? !func[0] : (func[1:0] != 2'b11);
    b_sgn = func[2] ? !func[0] : !func[1];
    sa    = a_sgn & op_a[XLEN-1];
    sb    = b_sgn & op_b[XLEN-1];
    abs_a = sa ? -op_a : op_a;
    abs_b = sb ? -op_b : op_b;
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
    dshift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    dtrial = dshift - {1'b0, mag};
  end

  always_comb begin
    mres = neg ? -acc : acc;
    dval = fn[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (!fn[2])
      fix_res = (fn[1:0] == 2'b00) ? mres[XLEN-1:0] : mres[2*XLEN-1:XLEN];
    else if (bzero)
      fix_res = fn[1] ? a_save : '1;
    else
      fix_res = neg ? -dval : dval;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (accept && is_m) state_nxt = func[2] ? DIV : MUL;
        MUL, DIV: if (last) state_nxt = FIX;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      fn        <= '0;
      neg       <= 1'b0;
      bzero     <= 1'b0;
      a_save    <= '0;
      mag       <= '0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (kill) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        fn <= func;
        if (is_m) begin
          cnt    <= '0;
          a_save <= op_a;
          bzero  <= (op_b == '0);
          // remainder takes the dividend's sign, everything else the product/quotient sign
          neg    <= (func[2] && func[1]) ? sa : (sa ^ sb);
          if (func[2]) begin
            acc <= {{XLEN{1'b0}}, abs_a};
            mag <= abs_b;
          end else begin
            acc <= {{XLEN{1'b0}}, abs_b};
            mag <= abs_a;
          end
        end else begin
          result    <= alu_res;
          out_valid <= 1'b1;
        end
      end
      case (state)
        MUL: if (!last) begin
          acc <= {msum, acc[XLEN-1:1]};
          cnt <= cnt + CW'(1);
        end
        DIV: if (!last) begin
          if (!dtrial[XLEN]) acc <= {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          else               acc <= {dshift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pipelined_exec_unit.md
PIPELINED_EXEC_UNIT -- requirements
Module: pipelined_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; legal values 8..64, powers of two.
REQ-002 SHALL derive SHW = log2(XLEN), the number of shift-amount bits taken from op_b.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  unit can accept an operation this cycle.
REQ-007 op_a, op_b  input  XLEN each  operands.
REQ-008 func  input  3  RV funct3 selector.
REQ-009 aux_func  input  7  RV funct7 selector.
REQ-010 kill  input  1  synchronous abort of the in-flight operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  XLEN  operation result.
REQ-014 busy  output  1  multi-cycle operation in progress.

Function
REQ-015 SHALL accept an operation when in_valid and in_ready are both high at a rising edge, capturing op_a, op_b, func and aux_func.
REQ-016 in_ready SHALL equal (state==IDLE) and (!out_valid or out_ready).
REQ-017 aux_func==7'b0000001 SHALL select an M-op; any other value SHALL select an ALU op, with aux_func[5] as the only decoded bit.
REQ-018 ALU ops SHALL be: 000 ADD/SUB (SUB when bit5=1), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when bit5=1), 110 OR, 111 AND.
REQ-019 Shifts SHALL use op_b[SHW-1:0] only; SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-020 ADD/SUB SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-021 ALU op result SHALL be registered, with out_valid high on the edge following acceptance (latency 1), and SHALL permit back-to-back accepts.
REQ-022 M-ops SHALL be: 000 MUL (low half), 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU (u×u), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-023 M-ops SHALL be computed iteratively, one bit per cycle: MUL by shift-add on operand magnitudes, DIV by restoring division, with sign fixed up on the last step.
REQ-024 State machine SHALL have states IDLE, MUL, DIV, FIX: accept M-op → MUL or DIV; after XLEN iterations → FIX; FIX → IDLE with out_valid set.
REQ-025 M-op out_valid SHALL rise exactly XLEN+2 edges after the accept edge.
REQ-026 busy SHALL be high in MUL, DIV and FIX states.
REQ-027 Divide by zero SHALL give quotient all-ones and remainder op_a, at normal latency.
REQ-028 Signed overflow (op_a = -2^(XLEN-1), op_b = -1) SHALL give DIV result op_a and REM result 0.
REQ-029 result and out_valid SHALL hold stable while out_valid is high and out_ready is low.
REQ-030 A result accepted in the same cycle a new ALU op is accepted SHALL be replaced by the new result with out_valid staying high.
REQ-031 kill high SHALL return the unit to IDLE and clear out_valid on that edge, discarding any in-flight or pending result.
REQ-032 kill SHALL take priority over a same-cycle accept; in_valid is ignored during that cycle.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, out_valid 0, busy 0, result 0, and iteration counter 0, regardless of the clock.
REQ-034 in_ready SHALL be 1 while rst_n is low, per REQ-016.
REQ-035 Reset asserted mid-M-op SHALL abandon the operation; the first accept after release SHALL behave as if from power-up.

Verification
REQ-036 ALU sweep, XLEN=32: 10+5 → 15; 10-5 → 5; 8<<2 → 32; -20>>>1 → -10; 16>>2 → 4; 5&3 → 1; 5^3 → 6; 5|3 → 7; each with out_valid one cycle after accept.
REQ-037 Compare: SLT(5,8) → 1; SLT(-5,-8) → 0; SLTU(-5,-8) → 0; SLL(1,33) → 2, confirming shamt masking.
REQ-038 M-ops: MUL(8,3) → 24 at accept+34 edges; MULH(-1,-1) → 0; MULHU(-1,-1) → 0xFFFFFFFE; DIV(-7,2) → -3; REM(-7,2) → -1; DIVU(7,0) → 0xFFFFFFFF; REM(7,0) → 7; DIV(0x80000000,-1) → 0x80000000.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles after a result → result stable, in_ready 0; release → result consumed, next accept same cycle.
REQ-040 Abort: kill at iteration 10 of a DIV → IDLE next edge, out_valid never rises; rst_n pulsed mid-MUL → outputs clear asynchronously, and subsequent ADD(1,2) → 3.
REQ-041 Parameter: rerun the ALU and M-op vectors at XLEN=16 → M-op latency 18 edges, results truncated to 16 bits.
